// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial WIDTH-bit adder with ready/valid on both sides.
// Operands are consumed LSB-first through one full-adder cell per clock with a
// registered carry; the assembled sum, carry-out and signed overflow are held
// in output registers until the consumer takes them.
module serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned LAST_BIT = WIDTH - 1;
  localparam int unsigned MSB_CIN  = WIDTH - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   s_sh_q, s_sh_d;
  logic               c_q, c_d;
  logic               c_msb_q, c_msb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_s;
  logic               fa_c;

  // Single full-adder cell working on the current LSBs and the carry register.
  assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
  assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

  // State and datapath registers; synchronous active-low reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      c_msb_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      c_msb_q <= c_msb_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update; every register holds unless its state acts on it.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    c_msb_d = c_msb_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          c_msb_d = 1'b0;
          cnt_d   = '0;
          s_sh_d  = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        s_sh_d = {fa_s, s_sh_q[WIDTH-1:1]};
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = fa_c;
        cnt_d  = cnt_q + CNT_W'(1);
        // The carry produced by bit WIDTH-2 is the carry into the sign bit.
        if (cnt_q == CNT_W'(MSB_CIN)) begin
          c_msb_d = fa_c;
        end
        // Last bit: publish the result registers straight from the adder cell.
        if (cnt_q == CNT_W'(LAST_BIT)) begin
          sum_d   = {fa_s, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_c;
          ovf_d   = c_msb_q ^ fa_c;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and status flags decode from the state register only.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
